// File: rtl/spi_target_pkg.sv
// Shared constants for the SPI target: register offsets, STATUS/FLAGS bit positions, frame width.
package spi_target_pkg;

    localparam int FRAME_W = 8;

    // Register word index, taken from wbs_adr_i[4:2]
    localparam logic [2:0] REG_RXDATA = 3'd0;
    localparam logic [2:0] REG_TXDATA = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_IER    = 3'd3;
    localparam logic [2:0] REG_FLAGS  = 3'd4;

    localparam int ST_RXNE   = 0;
    localparam int ST_RXFULL = 1;
    localparam int ST_TXE    = 2;
    localparam int ST_TXFULL = 3;
    localparam int ST_BUSY   = 4;

    localparam int FL_RXNE  = 0;
    localparam int FL_TXE   = 1;
    localparam int FL_RXOVF = 2;
    localparam int FL_TXUDR = 3;
    localparam int FL_ABORT = 4;

endpackage

// File: rtl/spi_target_fifo.sv
// Synchronous FIFO with first-word fall-through read data; push and pop in the same cycle both apply.
module spi_target_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/spi_target_wb.sv
// Wishbone SPI target: oversampled mode-0 SPI slave (MSB first, 8-bit frames) with RX/TX FIFOs,
// a small register file and a level interrupt.
module spi_target_wb
    import spi_target_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        irq,
    input  logic        spi_sck,
    input  logic        spi_ss,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(FRAME_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);

    logic [1:0] sck_s, ss_s, mosi_s;
    logic       sck_d, ss_d, mosi_d;
    logic       sck_rise, sck_fall, ss_rise, ss_fall;

    // The ss chain resets to "selected" so a frame already running at reset release shows
    // no falling edge and is ignored until ss goes high and falls again.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sck_s    <= '0;
            ss_s     <= '0;
            mosi_s   <= '0;
            sck_d    <= 1'b0;
            ss_d     <= 1'b0;
            mosi_d   <= 1'b0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            ss_rise  <= 1'b0;
            ss_fall  <= 1'b0;
        end else begin
            sck_s    <= {sck_s[0], spi_sck};
            ss_s     <= {ss_s[0], spi_ss};
            mosi_s   <= {mosi_s[0], spi_mosi};
            sck_d    <= sck_s[1];
            ss_d     <= ss_s[1];
            mosi_d   <= mosi_s[1];
            sck_rise <= sck_s[1] & ~sck_d;
            sck_fall <= ~sck_s[1] & sck_d;
            ss_rise  <= ss_s[1] & ~ss_d;
            ss_fall  <= ~ss_s[1] & ss_d;
        end
    end

    logic               active;
    logic               byte_done;
    logic [BW-1:0]      bit_cnt;
    logic [FRAME_W-1:0] rx_sr;
    logic [FRAME_W-1:0] tx_sr;
    logic               miso_r;

    logic         rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]   rx_rdata, rx_byte;
    logic [CW-1:0] rx_count;
    logic         tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]   tx_rdata, load_byte;
    logic [CW-1:0] tx_count;
    logic         load_req, set_udr, set_ovf, set_abort, bit_edge;

    assign bit_edge  = active & ~ss_rise & ~ss_fall;
    assign load_req  = ss_fall | (bit_edge & sck_fall & byte_done);
    assign tx_pop    = load_req & ~tx_empty;
    assign load_byte = tx_empty ? FILL_BYTE : tx_rdata;
    assign set_udr   = load_req & tx_empty;
    assign rx_byte   = {rx_sr[FRAME_W-2:0], mosi_d};
    assign rx_push   = bit_edge & sck_rise & (bit_cnt == LAST_BIT);
    assign set_ovf   = rx_push & rx_full & ~rx_pop;
    assign set_abort = ss_rise & active & (bit_cnt != '0);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            active    <= 1'b0;
            byte_done <= 1'b0;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            miso_r    <= 1'b0;
        end else if (ss_fall) begin
            active    <= 1'b1;
            byte_done <= 1'b0;
            bit_cnt   <= '0;
            tx_sr     <= load_byte;
            miso_r    <= load_byte[FRAME_W-1];
        end else if (ss_rise) begin
            active    <= 1'b0;
            byte_done <= 1'b0;
            bit_cnt   <= '0;
            miso_r    <= 1'b0;
        end else if (active) begin
            if (sck_rise) begin
                rx_sr     <= rx_byte;
                bit_cnt   <= bit_cnt + 1'b1;
                byte_done <= (bit_cnt == LAST_BIT);
            end else if (sck_fall) begin
                if (byte_done) begin
                    tx_sr     <= load_byte;
                    miso_r    <= load_byte[FRAME_W-1];
                    byte_done <= 1'b0;
                end else begin
                    tx_sr  <= {tx_sr[FRAME_W-2:0], 1'b0};
                    miso_r <= tx_sr[FRAME_W-2];
                end
            end
        end
    end

    assign spi_miso    = miso_r;
    assign spi_miso_oe = active;

    spi_target_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (rx_push),
        .wdata (rx_byte),
        .pop   (rx_pop),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    spi_target_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (tx_push),
        .wdata (wbs_dat_i[7:0]),
        .pop   (tx_pop),
        .rdata (tx_rdata),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // Wishbone: a request is a cyc&stb seen while ack is low; it completes on the next edge.
    logic        wb_req, wb_rd, wb_wr;
    logic [2:0]  reg_sel;
    logic [4:0]  ier;
    logic [4:2]  sticky;
    logic [4:0]  flags;
    logic [15:0] status;
    logic [31:0] rd_data;
    logic [4:2]  w1c;

    assign wb_req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wb_rd   = wb_req & ~wbs_we_i;
    assign wb_wr   = wb_req & wbs_we_i & wbs_sel_i[0];
    assign reg_sel = wbs_adr_i[4:2];
    assign rx_pop  = wb_rd & (reg_sel == REG_RXDATA) & ~rx_empty;
    assign tx_push = wb_wr & (reg_sel == REG_TXDATA);
    assign w1c     = (wb_wr && reg_sel == REG_FLAGS) ? wbs_dat_i[4:2] : 3'b000;

    always_comb begin
        flags           = '0;
        flags[FL_RXNE]  = ~rx_empty;
        flags[FL_TXE]   = tx_empty;
        flags[FL_RXOVF] = sticky[FL_RXOVF];
        flags[FL_TXUDR] = sticky[FL_TXUDR];
        flags[FL_ABORT] = sticky[FL_ABORT];
        status            = '0;
        status[ST_RXNE]   = ~rx_empty;
        status[ST_RXFULL] = rx_full;
        status[ST_TXE]    = tx_empty;
        status[ST_TXFULL] = tx_full;
        status[ST_BUSY]   = active;
        status[15:8]      = 8'(rx_count);
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_RXDATA: rd_data = rx_empty ? 32'h0 : {24'h0, rx_rdata};
            REG_STATUS: rd_data = {16'h0, status};
            REG_IER:    rd_data = {27'h0, ier};
            REG_FLAGS:  rd_data = {27'h0, flags};
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            ier       <= '0;
            sticky    <= '0;
            irq       <= 1'b0;
        end else begin
            wbs_ack_o <= wb_req;
            wbs_dat_o <= wb_rd ? rd_data : 32'h0;
            if (wb_wr && reg_sel == REG_IER) begin
                ier <= wbs_dat_i[4:0];
            end
            // Clear first, then OR in new events so a coincident set survives
            sticky <= (sticky & ~w1c) | {set_abort, set_udr, set_ovf};
            irq    <= |(flags & ier);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i[31:8], wbs_sel_i[3:1],
                           tx_count, tx_sr[FRAME_W-1]};

endmodule
